// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX paths.
//   uart_tx_state_t      : transmitter FSM state encoding
//   DEFAULT_CLKS_PER_BIT : 25 MHz system clock at 115200 baud
//   clks_per_bit()       : rounded clock-to-baud divider
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 217;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/baud_counter.sv
// Bit-time counter: counts 0..MAX_COUNT-1 and raises tick_o on the terminal
// count, then wraps to 0. clr_i holds the count at 0.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   clr_i   : synchronous clear
//   tick_o  : high during the terminal-count cycle
module baud_counter
    import uart_pkg::*;
#(
    parameter int MAX_COUNT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(MAX_COUNT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_cts.sv
// UART 8N1 transmitter with CTS flow control, fed by an AXI-Stream slave
// through a single-entry holding register.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   s_axis_tdata    : byte to send
//   s_axis_tvalid   : tdata valid
//   s_axis_tready   : holding register empty
//   cts             : asynchronous, 1 = peer busy, do not start a frame
//   tx              : registered serial line, idles high
//   busy            : a frame is on the line
//
// state | meaning
// IDLE  | line high, waiting for a held byte and cts_s low
// START | start bit (low) for one bit time
// DATA  | data bits, LSB first, one bit time each
// STOP  | stop bit(s) high; may chain straight into the next START
module uart_tx_cts
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int CLKS_PER_BIT    = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS       = 1,
    parameter int CTS_SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  cts,
    output logic                  tx,
    output logic                  busy
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_tx_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                    hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]           bit_idx_q, bit_idx_d;
    logic                    stop_cnt_q, stop_cnt_d;
    logic                    tx_q, tx_d;
    logic [CTS_SYNC_STAGES-1:0] cts_sync_q;
    logic                    cts_s;
    logic                    baud_tick;
    logic                    load;

    assign cts_s         = cts_sync_q[CTS_SYNC_STAGES-1];
    assign s_axis_tready = !hold_valid_q;
    assign tx            = tx_q;
    assign busy          = (state_q != IDLE);

    // Every transition out of a timed state happens on the tick, which already
    // wraps the counter; holding it clear in IDLE covers entry into START.
    baud_counter #(
        .MAX_COUNT (CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == IDLE),
        .tick_o (baud_tick)
    );

    // Preset to 1 so the line stays blocked until cts is seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_sync_q <= '1;
        end else begin
            cts_sync_q <= {cts_sync_q[CTS_SYNC_STAGES-2:0], cts};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            stop_cnt_q   <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            stop_cnt_q   <= stop_cnt_d;
            tx_q         <= tx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_idx_d    = bit_idx_q;
        stop_cnt_d   = stop_cnt_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        load         = 1'b0;

        case (state_q)
            IDLE: begin
                if (hold_valid_q && !cts_s) begin
                    load    = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d    = STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        if (hold_valid_q && !cts_s) begin
                            load    = 1'b1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            shreg_d = hold_q;
        end

        // tready is low whenever hold is full, so accept and load never coincide.
        if (s_axis_tvalid && !hold_valid_q) begin
            hold_valid_d = 1'b1;
            hold_d       = s_axis_tdata;
        end else if (load) begin
            hold_valid_d = 1'b0;
        end
    end

    // tx is registered from the next state so the line changes on the same
    // edge as the state it belongs to.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cts.sv
module tb_uart_tx_cts;

    localparam int BUDGET = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tdata_a = 8'h00, tdata_b = 8'h00;
    logic       tvalid_a = 1'b0, tvalid_b = 1'b0;
    logic       cts_a = 1'b0, cts_b = 1'b0;
    logic       tready_a, tready_b, tx_a, tx_b, busy_a, busy_b;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fd_a = 0;
    int fd_b = 0;

    typedef struct {
        logic [7:0] data;
        int         exp_start;
        bit         b2b;
    } item_t;

    item_t q_a[$];
    item_t q_b[$];

    uart_tx_cts u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (tdata_a),
        .s_axis_tvalid (tvalid_a),
        .s_axis_tready (tready_a),
        .cts           (cts_a),
        .tx            (tx_a),
        .busy          (busy_a)
    );

    uart_tx_cts #(
        .CLKS_PER_BIT (4),
        .STOP_BITS    (2)
    ) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (tdata_b),
        .s_axis_tvalid (tvalid_b),
        .s_axis_tready (tready_b),
        .cts           (cts_b),
        .tx            (tx_b),
        .busy          (busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic txv(input bit sel);
        return sel ? tx_b : tx_a;
    endfunction

    function automatic logic busyv(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    function automatic void push(input bit sel, input logic [7:0] d, input int es, input bit b);
        item_t it;
        it.data = d;
        it.exp_start = es;
        it.b2b = b;
        if (sel) q_b.push_back(it);
        else q_a.push_back(it);
    endfunction

    // Monitor: pops the expected frame, then checks the line cycle by cycle.
    task automatic run_monitor(input bit sel);
        int cpb, sb, w, bad, k, ncyc;
        logic [7:0] got;
        logic exp_bit;
        item_t it;
        cpb = sel ? 4 : 217;
        sb  = sel ? 2 : 1;
        ncyc = (9 + sb) * cpb;
        forever begin
            while ((sel ? q_b.size() : q_a.size()) == 0) @(negedge clk);
            it = sel ? q_b.pop_front() : q_a.pop_front();
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (txv(sel) !== 1'b0 && w < BUDGET);
            check(sel ? "b_start_seen" : "a_start_seen", txv(sel), 1'b0);
            if (txv(sel) === 1'b0) begin
                if (it.exp_start >= 0) check(sel ? "b_start_edge" : "a_start_edge", cyc, it.exp_start);
                if (it.b2b) check(sel ? "b_gap_cycles" : "a_gap_cycles", w, 1);
                bad = 0;
                got = 8'h00;
                for (int i = 0; i < ncyc; i++) begin
                    if (i > 0) @(negedge clk);
                    k = i / cpb;
                    exp_bit = (k == 0) ? 1'b0 : (k <= 8) ? it.data[k-1] : 1'b1;
                    if (txv(sel) !== exp_bit || busyv(sel) !== 1'b1) bad++;
                    if (k >= 1 && k <= 8 && (i % cpb) == cpb / 2) got[k-1] = txv(sel);
                end
                check(sel ? "b_frame_line_errs" : "a_frame_line_errs", bad, 0);
                check(sel ? "b_frame_data" : "a_frame_data", got, it.data);
            end
            if (sel) fd_b++;
            else fd_a++;
        end
    endtask

    initial run_monitor(1'b0);
    initial run_monitor(1'b1);

    task automatic send(input bit sel, input logic [7:0] d, input bit keep, output int acc);
        int n;
        n = 0;
        if (sel) begin tdata_b = d; tvalid_b = 1'b1; end
        else     begin tdata_a = d; tvalid_a = 1'b1; end
        while ((sel ? tready_b : tready_a) !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", sel ? tready_b : tready_a, 1'b1);
        acc = cyc + 1;
        @(posedge clk);
        #1;
        if (!keep) begin
            if (sel) tvalid_b = 1'b0;
            else     tvalid_a = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic wait_frames(input bit sel, input int target);
        int n;
        n = 0;
        while ((sel ? fd_b : fd_a) < target && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check("frames_done", sel ? fd_b : fd_a, target);
        @(negedge clk);
    endtask

    task automatic idle_check(input string name, input int ncyc, input logic exp_ready);
        int bad;
        bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (tx_a !== 1'b1 || busy_a !== 1'b0 || tready_a !== exp_ready) bad++;
            @(negedge clk);
        end
        check(name, bad, 0);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, c;

        #2 rst_n = 1'b0;
        #2;
        check("rst_tx_a", tx_a, 1'b1);
        check("rst_tready_a", tready_a, 1'b1);
        check("rst_busy_a", busy_a, 1'b0);
        check("rst_tx_b", tx_b, 1'b1);
        check("rst_tready_b", tready_b, 1'b1);
        check("rst_busy_b", busy_b, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: single byte 0xA5
        c = cyc;
        push(1'b0, 8'hA5, c + 2, 1'b0);
        send(1'b0, 8'hA5, 1'b0, a1);
        check("t1_accept_edge", a1, c + 1);
        wait_frames(1'b0, 1);
        check("t1_busy_after", busy_a, 1'b0);
        check("t1_tx_after", tx_a, 1'b1);

        // 2: 0x00, 0xFF, 0x55 streamed with tvalid held
        c = cyc;
        push(1'b0, 8'h00, c + 2, 1'b0);
        push(1'b0, 8'hFF, -1, 1'b1);
        push(1'b0, 8'h55, -1, 1'b1);
        send(1'b0, 8'h00, 1'b1, a1);
        send(1'b0, 8'hFF, 1'b1, a2);
        send(1'b0, 8'h55, 1'b0, a3);
        check("t2_accept2", a2, a1 + 2);
        check("t2_accept3", a3, a1 + 2172);
        wait_frames(1'b0, 4);
        check("t2_busy_after", busy_a, 1'b0);

        // 3: blocked by cts, then released
        cts_a = 1'b1;
        repeat (4) @(negedge clk);
        send(1'b0, 8'h3C, 1'b0, a1);
        idle_check("t3_blocked_errs", 30, 1'b0);
        c = cyc;
        push(1'b0, 8'h3C, c + 3, 1'b0);
        cts_a = 1'b0;
        wait_frames(1'b0, 5);
        check("t3_tready_after", tready_a, 1'b1);

        // 4: cts rises mid-frame of 0x81; queued 0x7E waits for cts low
        push(1'b0, 8'h81, -1, 1'b0);
        send(1'b0, 8'h81, 1'b0, a1);
        send(1'b0, 8'h7E, 1'b0, a2);
        check("t4_accept2", a2, a1 + 2);
        repeat (800) @(negedge clk);
        cts_a = 1'b1;
        wait_frames(1'b0, 6);
        idle_check("t4_held_errs", 300, 1'b0);
        c = cyc;
        push(1'b0, 8'h7E, c + 3, 1'b0);
        cts_a = 1'b0;
        wait_frames(1'b0, 7);

        // 5: reset during data bit 4
        send(1'b0, 8'h5A, 1'b0, a1);
        repeat (1200) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_tx", tx_a, 1'b1);
        check("t5_rst_tready", tready_a, 1'b1);
        check("t5_rst_busy", busy_a, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        idle_check("t5_residual_errs", 400, 1'b1);
        c = cyc;
        push(1'b0, 8'h12, c + 2, 1'b0);
        send(1'b0, 8'h12, 1'b0, a1);
        wait_frames(1'b0, 8);

        // 6: CLKS_PER_BIT=4, STOP_BITS=2 -> 44-cycle frames, back to back
        c = cyc;
        push(1'b1, 8'hC3, c + 2, 1'b0);
        push(1'b1, 8'h96, -1, 1'b1);
        send(1'b1, 8'hC3, 1'b1, a1);
        send(1'b1, 8'h96, 1'b0, a2);
        check("t6_accept2", a2, a1 + 2);
        wait_frames(1'b1, 2);
        check("t6_busy_after", busy_b, 1'b0);
        check("t6_tx_after", tx_b, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
